// File: rtl/mem2axi_bridge_if.sv
// AXI4 bus bundle (32-bit data) used between the mem2axi bridge and a crossbar slave port.
interface axi_intf #(
    parameter int ID_WIDTH = 10
) ();
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/mem2axi_bridge.sv
// Single-outstanding memory request port to AXI4 master; one 32-bit single-beat transfer per request.
//   state | meaning
//   IDLE  | waiting for s_cs, request fields latched on entry to a transfer
//   WADDR | AW and W offered independently, each dropped after its own handshake
//   WRESP | BREADY high, waiting for the write response
//   RADDR | ARVALID high until ARREADY
//   RDATA | RREADY high, waiting for read data
//   DONE  | completion cycle: s_busy low, s_do/s_err valid
module mem2axi_bridge #(
    parameter int                  ID_WIDTH = 10,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = '0,
    parameter logic [2:0]          AXI_PROT = 3'b000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_cs,
    input  logic        s_we,
    input  logic [31:0] s_addr,
    input  logic [3:0]  s_byte,
    input  logic [31:0] s_di,
    output logic [31:0] s_do,
    output logic        s_busy,
    output logic        s_err,
    axi_intf.master     m_axi_intf
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q, di_q, rdata_q;
    logic [3:0]  byte_q;
    logic        awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic        aw_done, w_done, err_q;
    logic        aw_hs, w_hs, ar_hs;
    logic        unused_ok;

    assign aw_hs = awvalid_q & m_axi_intf.awready;
    assign w_hs  = wvalid_q & m_axi_intf.wready;
    assign ar_hs = arvalid_q & m_axi_intf.arready;

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (s_cs) state_nx = s_we ? WADDR : RADDR;
            WADDR:   if ((aw_done | aw_hs) && (w_done | w_hs)) state_nx = WRESP;
            WRESP:   if (m_axi_intf.bvalid) state_nx = DONE;
            RADDR:   if (ar_hs) state_nx = RDATA;
            RDATA:   if (m_axi_intf.rvalid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q    <= '0;
            byte_q    <= '0;
            di_q      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_cs) begin
                        addr_q <= s_addr;
                        byte_q <= s_we ? s_byte : 4'b0000;
                        di_q   <= s_di;
                        if (s_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WADDR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (state_nx == WRESP) begin
                        bready_q <= 1'b1;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end
                end
                WRESP: begin
                    if (m_axi_intf.bvalid) begin
                        bready_q <= 1'b0;
                        err_q    <= m_axi_intf.bresp[1];
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (m_axi_intf.rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= m_axi_intf.rdata;
                        err_q    <= m_axi_intf.rresp[1];
                    end
                end
                DONE: begin
                    // completion data is only presented for one cycle
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign s_busy = s_cs && (state != DONE);
    assign s_do   = rdata_q;
    assign s_err  = err_q;

    assign m_axi_intf.awid    = AXI_ID;
    assign m_axi_intf.awaddr  = addr_q;
    assign m_axi_intf.awlen   = 8'd0;
    assign m_axi_intf.awsize  = 3'b010;
    assign m_axi_intf.awburst = 2'b01;
    assign m_axi_intf.awlock  = 1'b0;
    assign m_axi_intf.awcache = 4'b0000;
    assign m_axi_intf.awprot  = AXI_PROT;
    assign m_axi_intf.awvalid = awvalid_q;
    assign m_axi_intf.wdata   = di_q;
    assign m_axi_intf.wstrb   = byte_q;
    assign m_axi_intf.wlast   = 1'b1;
    assign m_axi_intf.wvalid  = wvalid_q;
    assign m_axi_intf.bready  = bready_q;
    assign m_axi_intf.arid    = AXI_ID;
    assign m_axi_intf.araddr  = addr_q;
    assign m_axi_intf.arlen   = 8'd0;
    assign m_axi_intf.arsize  = 3'b010;
    assign m_axi_intf.arburst = 2'b01;
    assign m_axi_intf.arlock  = 1'b0;
    assign m_axi_intf.arcache = 4'b0000;
    assign m_axi_intf.arprot  = AXI_PROT;
    assign m_axi_intf.arvalid = arvalid_q;
    assign m_axi_intf.rready  = rready_q;

    // response IDs and RLAST are not needed: the crossbar routes, every read is one beat
    assign unused_ok = ^{m_axi_intf.bid, m_axi_intf.rid, m_axi_intf.rlast,
                         m_axi_intf.bresp[0], m_axi_intf.rresp[0]};
endmodule
